// File: rtl/banked_mem_model.sv
// ---------------------------------------------------------------------------
// banked_mem_model
//
// Cycle-accurate banked memory model for the systolic wrapper benches.
// Each line holds BANKING_FACTOR words of DATA_WIDTH bits. Writes are
// per-bank masked. Reads are fully pipelined with a fixed MEM_LATENCY.
// Out-of-range accesses raise a sticky error flag. Accepted in-range reads
// and writes are counted.
//
// Ports
//   clk             rising-edge clock
//   rst             asynchronous active-low reset (flops only, not contents)
//   mem_read_en     read request, sampled on rising clk
//   mem_write_en    write request, sampled on rising clk
//   mem_req_addr    line address shared by read and write
//   mem_req_data    write data; bank b at [b*DATA_WIDTH +: DATA_WIDTH]
//   mem_write_mask  per-bank write enable
//   mem_resp_data   read data (holds its last value while not valid)
//   mem_resp_valid  mem_resp_data is valid this cycle
//   addr_error      sticky: an out-of-range access was seen since reset
//   read_count      accepted in-range reads since reset (wraps)
//   write_count     accepted in-range writes since reset (wraps)
//
// MEM_LATENCY must lie in 1..16 and DEPTH must not exceed 2**ADDRESS_WIDTH.
// ---------------------------------------------------------------------------
module banked_mem_model #(
    parameter int DATA_WIDTH     = 16,
    parameter int BANKING_FACTOR = 1,
    parameter int ADDRESS_WIDTH  = 13,
    parameter int DEPTH          = 1024,
    parameter int MEM_LATENCY    = 1,
    parameter int INIT_MODE      = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 mem_read_en,
    input  logic                                 mem_write_en,
    input  logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
    input  logic [BANKING_FACTOR-1:0]            mem_write_mask,
    output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
    output logic                                 mem_resp_valid,
    output logic                                 addr_error,
    output logic [31:0]                          read_count,
    output logic [31:0]                          write_count
);

    localparam int LINE_W = BANKING_FACTOR * DATA_WIDTH;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [LINE_W-1:0] line_t;

    // Power-up contents of one line.
    function automatic line_t init_line(input int line_addr);
        line_t v;
        v = '0;
        if (INIT_MODE == 1) begin
            for (int b = 0; b < BANKING_FACTOR; b++) begin
                v[b*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(line_addr * BANKING_FACTOR + b);
            end
        end
        return v;
    endfunction

    // Address decode. The compare is one bit wider than the address so that
    // DEPTH == 2**ADDRESS_WIDTH is represented exactly.
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             rd_take;   // read gets a response slot (even if out of range)
    logic             rd_hit;    // in-range read: counted
    logic             wr_hit;    // in-range write: updates contents, counted
    logic             oob_seen;

    assign in_range = {1'b0, mem_req_addr} < (ADDRESS_WIDTH + 1)'(DEPTH);
    assign idx      = mem_req_addr[IDX_W-1:0];
    // Requests presented while reset is held are ignored, so contents
    // cannot change underneath a reset.
    assign rd_take  = rst & mem_read_en;
    assign rd_hit   = rd_take & in_range;
    assign wr_hit   = rst & mem_write_en & in_range;
    assign oob_seen = rst & (mem_read_en | mem_write_en) & ~in_range;

    // Storage: one register per line, seeded once at time zero.
    line_t mem_rd [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : g_line
        line_t line_q = init_line(a);

        // NOTE: storage has no reset branch; contents must survive rst and
        // only take their initial value at time zero.
        always_ff @(posedge clk) begin
            if (wr_hit && idx == IDX_W'(a)) begin
                for (int b = 0; b < BANKING_FACTOR; b++) begin
                    if (mem_write_mask[b]) begin
                        line_q[b*DATA_WIDTH +: DATA_WIDTH] <= mem_req_data[b*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end

        assign mem_rd[a] = line_q;
    end

    // Sampled before the write lands at the same edge, which gives
    // read-before-write for a same-address read/write pair.
    line_t rd_line;
    assign rd_line = in_range ? mem_rd[idx] : '0;

    // Read pipeline. Stage MEM_LATENCY-1 is the response register. Data
    // stages only load when a valid read moves in, so the response data
    // holds its last value between valids.
    logic [MEM_LATENCY-1:0] pipe_vld;
    line_t                  pipe_data [MEM_LATENCY];

    // NOTE: all state updates use non-blocking assignments so every stage
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= rd_take;
            if (rd_take) begin
                pipe_data[0] <= rd_line;
            end
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_data[i] <= pipe_data[i-1];
                end
            end
        end
    end

    assign mem_resp_valid = pipe_vld[MEM_LATENCY-1];
    assign mem_resp_data  = pipe_data[MEM_LATENCY-1];

    // Error flag and access counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_error  <= 1'b0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (oob_seen) begin
                addr_error <= 1'b1;
            end
            if (rd_hit) begin
                read_count <= read_count + 32'd1;
            end
            if (wr_hit) begin
                write_count <= write_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_banked_mem_model.sv
// ---------------------------------------------------------------------------
// tb_banked_mem_model
//
// Directed bench for banked_mem_model using three instances:
//   u_a : 4 banks x 16b, DEPTH 1024, latency 3, counting init
//   u_b : 1 bank  x 16b, DEPTH 1024, latency 1, counting init
//   u_c : 2 banks x 16b, DEPTH 64,   latency 4, counting init
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_banked_mem_model;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance A ----------------
    logic        ab_rst;
    logic        a_rd, a_wr;
    logic [12:0] a_addr;
    logic [63:0] a_wdata;
    logic [3:0]  a_mask;
    logic [63:0] a_rdata;
    logic        a_vld, a_err;
    logic [31:0] a_rcnt, a_wcnt;

    banked_mem_model #(
        .DATA_WIDTH(16), .BANKING_FACTOR(4), .ADDRESS_WIDTH(13),
        .DEPTH(1024), .MEM_LATENCY(3), .INIT_MODE(1)
    ) u_a (
        .clk(clk), .rst(ab_rst),
        .mem_read_en(a_rd), .mem_write_en(a_wr),
        .mem_req_addr(a_addr), .mem_req_data(a_wdata), .mem_write_mask(a_mask),
        .mem_resp_data(a_rdata), .mem_resp_valid(a_vld), .addr_error(a_err),
        .read_count(a_rcnt), .write_count(a_wcnt)
    );

    // ---------------- instance B ----------------
    logic        b_rd, b_wr;
    logic [12:0] b_addr;
    logic [15:0] b_wdata;
    logic [0:0]  b_mask;
    logic [15:0] b_rdata;
    logic        b_vld, b_err;
    logic [31:0] b_rcnt, b_wcnt;

    banked_mem_model #(
        .DATA_WIDTH(16), .BANKING_FACTOR(1), .ADDRESS_WIDTH(13),
        .DEPTH(1024), .MEM_LATENCY(1), .INIT_MODE(1)
    ) u_b (
        .clk(clk), .rst(ab_rst),
        .mem_read_en(b_rd), .mem_write_en(b_wr),
        .mem_req_addr(b_addr), .mem_req_data(b_wdata), .mem_write_mask(b_mask),
        .mem_resp_data(b_rdata), .mem_resp_valid(b_vld), .addr_error(b_err),
        .read_count(b_rcnt), .write_count(b_wcnt)
    );

    // ---------------- instance C ----------------
    logic        c_rst;
    logic        c_rd, c_wr;
    logic [7:0]  c_addr;
    logic [31:0] c_wdata;
    logic [1:0]  c_mask;
    logic [31:0] c_rdata;
    logic        c_vld, c_err;
    logic [31:0] c_rcnt, c_wcnt;

    banked_mem_model #(
        .DATA_WIDTH(16), .BANKING_FACTOR(2), .ADDRESS_WIDTH(8),
        .DEPTH(64), .MEM_LATENCY(4), .INIT_MODE(1)
    ) u_c (
        .clk(clk), .rst(c_rst),
        .mem_read_en(c_rd), .mem_write_en(c_wr),
        .mem_req_addr(c_addr), .mem_req_data(c_wdata), .mem_write_mask(c_mask),
        .mem_resp_data(c_rdata), .mem_resp_valid(c_vld), .addr_error(c_err),
        .read_count(c_rcnt), .write_count(c_wcnt)
    );

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Power-up line of instance A: bank b of line n holds 4n+b.
    function automatic logic [63:0] line4(input int n);
        return {16'(4*n + 3), 16'(4*n + 2), 16'(4*n + 1), 16'(4*n)};
    endfunction

    initial begin
        ab_rst = 1'b0; c_rst = 1'b0;
        a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0; a_mask = '0;
        b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0; b_mask = '0;
        c_rd = 0; c_wr = 0; c_addr = '0; c_wdata = '0; c_mask = '0;

        // ---- reset state ----
        step();
        check("rst_a_vld",  64'(a_vld),  64'd0);
        check("rst_a_data", a_rdata,     64'd0);
        check("rst_a_err",  64'(a_err),  64'd0);
        check("rst_a_rcnt", 64'(a_rcnt), 64'd0);
        check("rst_a_wcnt", 64'(a_wcnt), 64'd0);
        check("rst_b_data", 64'(b_rdata), 64'd0);
        check("rst_c_vld",  64'(c_vld),  64'd0);
        ab_rst = 1'b1; c_rst = 1'b1;

        // ---- 1: single read, latency 3 ----
        a_rd = 1; a_addr = 13'd5;
        step(); a_rd = 0;
        check("t1_vld_e0", 64'(a_vld), 64'd0);
        step();
        check("t1_vld_e1", 64'(a_vld), 64'd0);
        step();
        check("t1_vld_e2", 64'(a_vld), 64'd1);
        check("t1_data",   a_rdata,    64'h0017_0016_0015_0014);
        step();
        check("t1_vld_e3",  64'(a_vld), 64'd0);
        check("t1_hold",    a_rdata,    64'h0017_0016_0015_0014);
        check("t1_rcnt",    64'(a_rcnt), 64'd1);

        // ---- 2: back-to-back reads 0..3 ----
        for (int i = 0; i < 4; i++) begin
            a_rd = 1; a_addr = 13'(i);
            step();
            if (i < 2) begin
                check("t2_vld_early", 64'(a_vld), 64'd0);
            end else begin
                check("t2_vld", 64'(a_vld), 64'd1);
                check("t2_data", a_rdata, line4(i - 2));
            end
        end
        a_rd = 0;
        step();
        check("t2_vld_l2",  64'(a_vld), 64'd1);
        check("t2_data_l2", a_rdata,    line4(2));
        step();
        check("t2_vld_l3",  64'(a_vld), 64'd1);
        check("t2_data_l3", a_rdata,    line4(3));
        step();
        check("t2_vld_after", 64'(a_vld), 64'd0);
        check("t2_rcnt",      64'(a_rcnt), 64'd5);

        // ---- 3: masked write then read ----
        a_wr = 1; a_addr = 13'd7; a_wdata = 64'h000D_000C_000B_000A; a_mask = 4'b0101;
        step();
        a_wr = 0; a_rd = 1; a_addr = 13'd7;
        step(); a_rd = 0;
        step();
        step();
        check("t3_vld",  64'(a_vld), 64'd1);
        check("t3_data", a_rdata,    64'h001F_000C_001D_000A);
        check("t3_wcnt", 64'(a_wcnt), 64'd1);
        check("t3_err",  64'(a_err),  64'd0);

        // all-zero mask: counted but contents unchanged
        a_wr = 1; a_addr = 13'd8; a_wdata = '1; a_mask = 4'b0000;
        step(); a_wr = 0;
        check("t3_wcnt_mask0", 64'(a_wcnt), 64'd2);
        a_rd = 1; a_addr = 13'd8;
        step(); a_rd = 0;
        step();
        step();
        check("t3_mask0_vld",  64'(a_vld), 64'd1);
        check("t3_mask0_data", a_rdata,    line4(8));
        check("t3_rcnt",       64'(a_rcnt), 64'd7);

        // ---- 5: out-of-range read and write ----
        a_rd = 1; a_addr = 13'd1024;
        step(); a_rd = 0;
        check("t5_err_set", 64'(a_err),  64'd1);
        check("t5_rcnt",    64'(a_rcnt), 64'd7);
        step();
        check("t5_vld_e1", 64'(a_vld), 64'd0);
        step();
        check("t5_vld",  64'(a_vld), 64'd1);
        check("t5_data", a_rdata,    64'd0);
        a_wr = 1; a_addr = 13'd2000; a_wdata = '1; a_mask = 4'b1111;
        step(); a_wr = 0;
        check("t5_err_hold", 64'(a_err),  64'd1);
        check("t5_wcnt",     64'(a_wcnt), 64'd2);
        // 2000 would alias to 976 if the range check were missing
        a_rd = 1; a_addr = 13'd976;
        step(); a_rd = 0;
        step();
        step();
        check("t5_alias_vld",  64'(a_vld), 64'd1);
        check("t5_alias_data", a_rdata,    line4(976));
        check("t5_rcnt2",      64'(a_rcnt), 64'd8);

        // ---- 4: same-edge write and read, latency 1 ----
        b_wr = 1; b_rd = 1; b_addr = 13'd2; b_wdata = 16'hBEEF; b_mask = 1'b1;
        step();
        b_wr = 0;
        check("t4_vld",  64'(b_vld),   64'd1);
        check("t4_old",  64'(b_rdata), 64'd2);
        check("t4_rcnt", 64'(b_rcnt),  64'd1);
        check("t4_wcnt", 64'(b_wcnt),  64'd1);
        step(); b_rd = 0;
        check("t4_new",   64'(b_rdata), 64'hBEEF);
        check("t4_rcnt2", 64'(b_rcnt),  64'd2);
        step();
        check("t4_vld_low", 64'(b_vld),   64'd0);
        check("t4_hold",    64'(b_rdata), 64'hBEEF);
        check("t4_err",     64'(b_err),   64'd0);

        // ---- 6: reset with reads in flight, latency 4 ----
        c_wr = 1; c_addr = 8'd10; c_wdata = 32'h2222_1111; c_mask = 2'b11;
        step(); c_wr = 0;
        for (int i = 0; i < 3; i++) begin
            c_rd = 1; c_addr = 8'(i);
            step();
        end
        c_rd = 0;
        check("t6_vld_pre",  64'(c_vld),  64'd0);
        check("t6_rcnt_pre", 64'(c_rcnt), 64'd3);
        c_rst = 1'b0;
        #1;
        check("t6_rcnt_rst", 64'(c_rcnt), 64'd0);
        check("t6_wcnt_rst", 64'(c_wcnt), 64'd0);
        step();
        c_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_no_vld", 64'(c_vld), 64'd0);
        end
        c_rd = 1; c_addr = 8'd10;
        step();
        c_addr = 8'd11;
        step(); c_rd = 0;
        step();
        check("t6_vld_e2", 64'(c_vld), 64'd0);
        step();
        check("t6_vld_w",  64'(c_vld),   64'd1);
        check("t6_kept",   64'(c_rdata), 64'h2222_1111);
        step();
        check("t6_vld_i",  64'(c_vld),   64'd1);
        check("t6_init",   64'(c_rdata), 64'h0017_0016);
        step();
        check("t6_vld_end", 64'(c_vld),  64'd0);
        check("t6_rcnt",    64'(c_rcnt), 64'd2);
        check("t6_err",     64'(c_err),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
